// File: rtl/swing_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : swing_sequencer_if
//  Description : Control and status bundle between the metronome tempo logic
//                and the swing sequencer (tempo/amplitude in, angle/beat out).
//  Revision    : 1.0  initial release
// ============================================================================
interface swing_sequencer_if;
   logic [9:0]  tempo;
   logic [31:0] amplitude;
   logic        frame_tick;
   logic        enable;
   logic [31:0] angle;
   logic        beat;
   logic        dir;
   logic        busy;

   modport master (
      output tempo, amplitude, frame_tick, enable,
      input  angle, beat, dir, busy
   );

   modport slave (
      input  tempo, amplitude, frame_tick, enable,
      output angle, beat, dir, busy
   );
endinterface
`default_nettype wire

// File: rtl/swing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : swing_sequencer
//  Description : Turns swing amplitude and tempo into a per-frame pendulum
//                angle sweeping -amp..+amp once per beat. The per-frame step
//                (2*amp*tempo / (60*FRAME_RATE)) is rebuilt by a shift-add
//                multiply followed by a restoring divide whenever the inputs
//                change. A beat pulse marks each end of the swing.
//                Optional: define SWING_TEMPO_CLAMP_EN to clamp nonzero tempo
//                into [59, 240] before it is latched.
//  Revision    : 1.0  initial release
// ============================================================================
module swing_sequencer #(
   parameter int FRAME_RATE = 60,
   parameter int MUL_CYCLES = 10,
   parameter int DIV_CYCLES = 40
) (
   input  logic             clk,
   input  logic             reset,
   swing_sequencer_if.slave bus
);

   // Divisor must stay below 2^31 so the remainder fits in 31 bits.
   localparam logic [31:0] c_beat_den = 32'(60 * FRAME_RATE);
   localparam logic [7:0]  c_mul_last = 8'(MUL_CYCLES - 1);
   localparam logic [7:0]  c_div_last = 8'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t      r_state;
   logic [9:0]  r_tempo;
   logic [31:0] r_amp;
   logic [39:0] r_mcand;
   logic [9:0]  r_mplier;
   logic [39:0] r_prod;      // product during MUL, quotient shifts in during DIV
   logic [30:0] r_rem;
   logic [7:0]  r_cnt;
   logic [31:0] r_step;
   logic [31:0] r_angle;
   logic        r_dir;
   logic        r_beat;
   logic        r_busy;

   logic [9:0]  w_tempo_eff;
   logic        w_change;
   logic        w_new_zero;
   logic [31:0] w_trial;
   logic        w_ge;
   logic [39:0] w_quo;
   logic signed [32:0] w_angle_x;
   logic signed [32:0] w_amp_x;
   logic signed [32:0] w_up;
   logic signed [32:0] w_dn;

`ifdef SWING_TEMPO_CLAMP_EN
   // Clamp a running tempo into the supported range; zero still means stop.
   always_comb begin
      w_tempo_eff = bus.tempo;
      if (bus.tempo == 10'd0)
         w_tempo_eff = 10'd0;
      else if (bus.tempo < 10'd59)
         w_tempo_eff = 10'd59;
      else if (bus.tempo > 10'd240)
         w_tempo_eff = 10'd240;
   end
`else
   assign w_tempo_eff = bus.tempo;
`endif

   assign w_change   = (w_tempo_eff != r_tempo) || (bus.amplitude != r_amp);
   assign w_new_zero = (w_tempo_eff == 10'd0) || (bus.amplitude == 32'd0);

   // One restoring-divide step: bring down the next dividend bit and try
   // subtracting the divisor.
   assign w_trial = {r_rem, r_prod[39]};
   assign w_ge    = (w_trial >= c_beat_den);
   assign w_quo   = {r_prod[38:0], w_ge};

   // 33-bit signed view of the swing so that +/- step can never wrap.
   assign w_angle_x = {r_angle[31], r_angle};
   assign w_amp_x   = {1'b0, r_amp};
   assign w_up      = w_angle_x + $signed({1'b0, r_step});
   assign w_dn      = w_angle_x - $signed({1'b0, r_step});

   // Sequencer: change detect, step computation and per-frame swing update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_tempo  <= '0;
         r_amp    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_step   <= '0;
         r_angle  <= '0;
         r_dir    <= 1'b1;
         r_beat   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_beat <= 1'b0;
         if (w_change) begin
            // New inputs win over everything, including a coincident tick.
            r_tempo  <= w_tempo_eff;
            r_amp    <= bus.amplitude;
            r_mcand  <= {11'd0, bus.amplitude[27:0], 1'b0};
            r_mplier <= w_tempo_eff;
            r_prod   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_new_zero) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_angle <= '0;
               r_dir   <= 1'b1;
            end else begin
               r_state <= S_MUL;
               r_busy  <= 1'b1;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_angle <= '0;
                  r_dir   <= 1'b1;
               end
               S_MUL: begin
                  if (r_mplier[0])
                     r_prod <= r_prod + r_mcand;
                  r_mcand  <= {r_mcand[38:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[9:1]};
                  if (r_cnt == c_mul_last) begin
                     r_cnt   <= '0;
                     r_state <= S_DIV;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_DIV: begin
                  r_rem  <= w_ge ? 31'(w_trial - c_beat_den) : w_trial[30:0];
                  r_prod <= w_quo;
                  if (r_cnt == c_div_last) begin
                     r_cnt   <= '0;
                     r_step  <= w_quo[31:0];
                     r_state <= S_RUN;
                     r_busy  <= 1'b0;
                     // A smaller amplitude may leave the pendulum out of range.
                     if (w_angle_x > w_amp_x)
                        r_angle <= r_amp;
                     else if (w_angle_x < -w_amp_x)
                        r_angle <= -r_amp;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_RUN: begin
                  // A zero step leaves the pendulum frozen without beats.
                  if (bus.frame_tick && bus.enable && (r_step != 32'd0)) begin
                     if (r_dir) begin
                        if (w_up >= w_amp_x) begin
                           r_angle <= r_amp;
                           r_dir   <= 1'b0;
                           r_beat  <= 1'b1;
                        end else begin
                           r_angle <= w_up[31:0];
                        end
                     end else begin
                        if (w_dn <= -w_amp_x) begin
                           r_angle <= -r_amp;
                           r_dir   <= 1'b1;
                           r_beat  <= 1'b1;
                        end else begin
                           r_angle <= w_dn[31:0];
                        end
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
         // Parked pendulum: centred, ready to restart upward, no beats.
         if (!bus.enable) begin
            r_angle <= '0;
            r_dir   <= 1'b1;
            r_beat  <= 1'b0;
         end
      end
   end

   assign bus.angle = r_angle;
   assign bus.beat  = r_beat;
   assign bus.dir   = r_dir;
   assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_swing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swing_sequencer
//  Description : Self-checking bench for swing_sequencer. A reference model
//                predicts angle/dir/beat per frame tick; predictions are
//                queued when the tick is driven and popped on the DUT update.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_swing_sequencer;

   localparam logic [31:0] c_amp4  = 32'h02D82D83;
   localparam logic [31:0] c_amp1  = 32'h00B60B60;
   localparam longint      c_deg3  = 64'h0222_2220;

   typedef struct {
      logic [31:0] angle;
      logic        dir;
      logic        beat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // reference model state
   longint m_angle;
   longint m_amp;
   longint m_step;
   int     m_tempo;
   bit     m_dir;
   bit     m_run;
   bit     m_en;

   swing_sequencer_if bus ();

   swing_sequencer #(
      .FRAME_RATE (60),
      .MUL_CYCLES (10),
      .DIV_CYCLES (40)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_tempo(input int t);
`ifdef SWING_TEMPO_CLAMP_EN
      if (t == 0)   return 0;
      if (t < 59)   return 59;
      if (t > 240)  return 240;
`endif
      return t;
   endfunction

   task automatic model_tick(output logic bt);
      longint nx;
      bt = 1'b0;
      if (!m_en) begin
         m_angle = 0;
         m_dir   = 1'b1;
      end else if (m_run && m_step != 0) begin
         if (m_dir) begin
            nx = m_angle + m_step;
            if (nx >= m_amp) begin
               m_angle = m_amp; m_dir = 1'b0; bt = 1'b1;
            end else m_angle = nx;
         end else begin
            nx = m_angle - m_step;
            if (nx <= -m_amp) begin
               m_angle = -m_amp; m_dir = 1'b1; bt = 1'b1;
            end else m_angle = nx;
         end
      end
   endtask

   task automatic do_tick();
      exp_t e;
      logic bt;
      model_tick(bt);
      e.angle = 32'(m_angle);
      e.dir   = m_dir;
      e.beat  = bt;
      sb.push_back(e);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      e = sb.pop_front();
      check("tick_angle", {32'd0, bus.angle}, {32'd0, e.angle});
      check("tick_dir",   {63'd0, bus.dir},   {63'd0, e.dir});
      check("tick_beat",  {63'd0, bus.beat},  {63'd0, e.beat});
   endtask

   task automatic apply(input int t, input longint a);
      int te;
      bus.tempo     = 10'(t);
      bus.amplitude = 32'(a);
      te = eff_tempo(t);
      if (te != m_tempo || a != m_amp) begin
         m_tempo = te;
         m_amp   = a;
         if (te == 0 || a == 0) begin
            m_run = 1'b0; m_angle = 0; m_dir = 1'b1;
         end else begin
            m_run  = 1'b1;
            m_step = ((2 * a * te) / 3600) & 64'hFFFF_FFFF;
            if (m_angle > m_amp)       m_angle = m_amp;
            else if (m_angle < -m_amp) m_angle = -m_amp;
         end
      end
   endtask

   task automatic busy_len(input logic [31:0] held, output int n, output bit moved);
      n = 0;
      moved = 1'b0;
      for (int i = 0; i < 10 && !bus.busy; i++) begin
         @(posedge clk); #1;
         if (bus.angle !== held) moved = 1'b1;
      end
      while (bus.busy && n < 200) begin
         n++;
         if (bus.angle !== held) moved = 1'b1;
         @(posedge clk); #1;
      end
      bus.frame_tick = 1'b0;
   endtask

   initial begin
      int     n;
      int     k;
      bit     mv;
      longint prev;
      longint d;
      logic [31:0] want;

      reset = 1'b1;
      bus.tempo = '0; bus.amplitude = '0; bus.frame_tick = 1'b0; bus.enable = 1'b0;
      m_angle = 0; m_amp = 0; m_step = 0; m_tempo = 0; m_dir = 1'b1; m_run = 1'b0; m_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_angle", {32'd0, bus.angle}, 64'd0);
      check("rst_dir",   {63'd0, bus.dir},   64'd1);
      check("rst_beat",  {63'd0, bus.beat},  64'd0);
      check("rst_busy",  {63'd0, bus.busy},  64'd0);

      // Bring-up at 60 BPM, 4 degrees.
      bus.enable = 1'b1; m_en = 1'b1;
      apply(60, c_amp4);
      busy_len(32'd0, n, mv);
      check("busy_len", 64'(n), 64'd50);
      check("busy_held", {63'd0, mv}, 64'd0);
      do_tick();
      check("first_step", {32'd0, bus.angle}, 64'h001845C8);

      k = 1;
      while (!bus.beat && k < 200) begin do_tick(); k++; end
      check("first_beat_tick",  64'(k), 64'd31);
      check("first_beat_angle", {32'd0, bus.angle}, {32'd0, c_amp4});
      check("first_beat_dir",   {63'd0, bus.dir}, 64'd0);

      want = -c_amp4;
      for (int r = 0; r < 2; r++) begin
         k = 0;
         do begin do_tick(); k++; end while (!bus.beat && k < 200);
         check("beat_gap",   64'(k), 64'd61);
         check("beat_angle", {32'd0, bus.angle}, {32'd0, want});
         want = -want;
      end

      // Shrink amplitude mid-swing with ticks held high throughout.
      k = 0;
      while (m_angle > c_deg3 && k < 20) begin do_tick(); k++; end
      prev = m_angle;
      bus.frame_tick = 1'b1;
      apply(60, c_amp1);
      busy_len(32'(prev), n, mv);
      check("shrink_busy_len", 64'(n), 64'd50);
      check("shrink_held",     {63'd0, mv}, 64'd0);
      check("shrink_clamp",    {32'd0, bus.angle}, {32'd0, c_amp1});
      check("shrink_dir",      {63'd0, bus.dir}, 64'd0);
      repeat (70) do_tick();

      // Tempo change during DIV restarts the computation.
      apply(60, c_amp4);
      for (int i = 0; i < 10 && !bus.busy; i++) begin @(posedge clk); #1; end
      check("restart_rise", {63'd0, bus.busy}, 64'd1);
      repeat (29) begin @(posedge clk); #1; end
      apply(120, c_amp4);
      @(posedge clk); #1;
      n = 0;
      while (bus.busy && n < 200) begin n++; @(posedge clk); #1; end
      check("restart_busy_len", 64'(n), 64'd50);
      prev = m_angle;
      do_tick();
      d = longint'($signed(bus.angle)) - prev;
      if (d < 0) d = -d;
      check("restart_step", d, 64'h00308B91);
      repeat (10) do_tick();

      // Park and re-enable.
      bus.enable = 1'b0; m_en = 1'b0; m_angle = 0; m_dir = 1'b1;
      @(posedge clk); #1;
      check("park_angle", {32'd0, bus.angle}, 64'd0);
      check("park_dir",   {63'd0, bus.dir},   64'd1);
      do_tick();
      bus.enable = 1'b1; m_en = 1'b1;
      repeat (3) do_tick();

      // Tempo zero stops the pendulum.
      apply(0, c_amp4);
      @(posedge clk); #1;
      check("idle_angle", {32'd0, bus.angle}, 64'd0);
      check("idle_busy",  {63'd0, bus.busy},  64'd0);
      check("idle_beat",  {63'd0, bus.beat},  64'd0);
      repeat (5) do_tick();

      // Reset in the middle of a computation.
      apply(60, c_amp4);
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_busy",  {63'd0, bus.busy},  64'd0);
      check("midrst_angle", {32'd0, bus.angle}, 64'd0);
      m_angle = 0; m_dir = 1'b1;
      busy_len(32'd0, n, mv);
      check("midrst_busy_len", 64'(n), 64'd50);
      repeat (5) do_tick();

      // Out-of-range tempos (clamped only when the option is built in).
      apply(300, c_amp4);
      busy_len(32'(m_angle), n, mv);
      check("t300_busy_len", 64'(n), 64'd50);
      repeat (5) do_tick();
      apply(10, c_amp4);
      busy_len(32'(m_angle), n, mv);
      check("t10_busy_len", 64'(n), 64'd50);
      repeat (5) do_tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
